sram_arbiter: RTL and testbench

- Shares the external 256K x 32 asynchronous SRAM (addr, data, ramcs_n, be_n, xwe_n, xrd_n) between two requesters: port 0 is the defectoscope receive-data writer and port 1 is the NIOS CPU bridge.
- Runs one FSM per transaction and arbitrates round-robin between the ports.
- Produces SRAM strobes with programmable access width.
- Instantiated in new_cntr_som. The top level builds the data tristate from data_oe, data_out and data_in.

---
 rtl/sram_pkg.sv | 28 ++
 rtl/sram_rr_arb2.sv | 72 +++++++
 rtl/sram_arbiter.sv | 168 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the external SRAM arbiter.
//   - FSM state encoding (IDLE/SETUP/ACCESS/HOLD)
//   - SRAM geometry (word address and data widths)
//   - Idle levels of the chip-select and byte-enable strobes
//   - port_mask(): converts a port number into a one-hot 2-bit pulse vector
package sram_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t SETUP  = 2'd1;
    localparam state_t ACCESS = 2'd2;
    localparam state_t HOLD   = 2'd3;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 32;

    localparam logic [1:0] CS_IDLE = 2'b11;
    localparam logic [3:0] BE_IDLE = 4'hF;

    // Fixed-priority mode: consecutive port-0 tie wins before port 1 is forced in.
    localparam logic [3:0] STARVE_LIMIT = 4'd8;

    function automatic logic [1:0] port_mask(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-input request picker for the SRAM arbiter.
// Ports:
//   clk     in  system clock
//   reset_n in  asynchronous active-low reset
//   req     in  [1:0] pending requests (only meaningful while the FSM is idle)
//   accept  in  the current pick is being taken this cycle
//   sel     out chosen port (0/1), valid when req != 0
//   valid   out at least one request pending
// Build option SRAM_ARB_FIXED_PRIO_EN: port 0 wins ties, except that after
// STARVE_LIMIT consecutive port-0 wins against a pending port 1, port 1 is
// granted once. Without it, ties alternate using the last-winner pointer.
module sram_rr_arb2
    import sram_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       sel,
    output logic       valid
);

    assign valid = |req;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    logic [3:0] streak_reg;

    always_comb begin
        sel = 1'b0;
        case (req)
            2'b10:   sel = 1'b1;
            2'b11:   sel = (streak_reg >= STARVE_LIMIT);
            default: sel = 1'b0;
        endcase
    end

    // Counts port-0 wins that happened while port 1 was also waiting; any
    // other grant breaks the run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            streak_reg <= 4'd0;
        end else if (accept) begin
            if (!sel && req[1]) begin
                streak_reg <= streak_reg + 4'd1;
            end else begin
                streak_reg <= 4'd0;
            end
        end
    end
`else
    // Reset to 1 so that port 0 takes the first tie.
    logic last_reg;

    always_comb begin
        sel = 1'b0;
        case (req)
            2'b10:   sel = 1'b1;
            2'b11:   sel = ~last_reg;
            default: sel = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_reg <= 1'b1;
        end else if (accept) begin
            last_reg <= sel;
        end
    end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Shares one external 256K x 32 asynchronous SRAM between two requesters
// (port 0: receive-data writer, port 1: CPU bridge). One transaction runs
// IDLE (arbitrate/capture) -> SETUP (gnt) -> ACCESS x WAIT_CYC -> HOLD.
// Parameters: WAIT_CYC (1..15) strobe low width, AW word address width.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   req[1:0], we[1:0]       per-port request (held until gnt) and direction
//   p0_/p1_addr, _be_n, _wdata  per-port transaction fields
//   gnt[1:0], rvalid[1:0]   one-cycle accept / read-data-valid pulses
//   rdata, busy             shared read data, FSM not idle
//   addr, ramcs_n, be_n, xwe_n, xrd_n  SRAM address and strobes
//   data_out, data_oe, data_in         pad data path (tristate built above)
// Build option SRAM_ARB_FIXED_PRIO_EN selects fixed priority with a
// starvation guard in sram_rr_arb2 instead of round-robin.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int WAIT_CYC = 2,
    parameter int AW       = SRAM_AW
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          req,
    input  logic [1:0]          we,
    input  logic [AW-1:0]       p0_addr,
    input  logic [AW-1:0]       p1_addr,
    input  logic [3:0]          p0_be_n,
    input  logic [3:0]          p1_be_n,
    input  logic [SRAM_DW-1:0]  p0_wdata,
    input  logic [SRAM_DW-1:0]  p1_wdata,
    output logic [1:0]          gnt,
    output logic [1:0]          rvalid,
    output logic [SRAM_DW-1:0]  rdata,
    output logic                busy,
    output logic [AW-1:0]       addr,
    output logic [1:0]          ramcs_n,
    output logic [3:0]          be_n,
    output logic                xwe_n,
    output logic                xrd_n,
    output logic [SRAM_DW-1:0]  data_out,
    output logic                data_oe,
    input  logic [SRAM_DW-1:0]  data_in
);

    localparam logic [3:0] ACCESS_LAST = 4'(WAIT_CYC - 1);

    state_t             state_reg, state_next;
    logic [3:0]         cnt_reg;
    logic               sel_reg;
    logic               we_reg;
    logic [AW-1:0]      addr_reg;
    logic [3:0]         be_reg;
    logic [SRAM_DW-1:0] wdata_reg;
    logic [SRAM_DW-1:0] rdata_reg;

    logic arb_sel;
    logic arb_valid;
    logic accept;

    // Requests are only looked at in IDLE; anything that happens to req
    // during a transaction is invisible until the FSM returns.
    assign accept = (state_reg == IDLE) && arb_valid;

    sram_rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .accept  (accept),
        .sel     (arb_sel),
        .valid   (arb_valid)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (cnt_reg == 4'd0) state_next = HOLD;
            HOLD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Transaction capture, access timer and read capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg   <= 4'd0;
            sel_reg   <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            be_reg    <= BE_IDLE;
            wdata_reg <= '0;
            rdata_reg <= '0;
        end else begin
            if (accept) begin
                sel_reg   <= arb_sel;
                we_reg    <= arb_sel ? we[1]    : we[0];
                addr_reg  <= arb_sel ? p1_addr  : p0_addr;
                be_reg    <= arb_sel ? p1_be_n  : p0_be_n;
                wdata_reg <= arb_sel ? p1_wdata : p0_wdata;
            end
            if (state_reg == SETUP) begin
                cnt_reg <= ACCESS_LAST;
            end else if (state_reg == ACCESS && cnt_reg != 4'd0) begin
                cnt_reg <= cnt_reg - 4'd1;
            end
            // Sample the pads on the edge that closes the last strobe cycle,
            // while xrd_n is still low.
            if (state_reg == ACCESS && cnt_reg == 4'd0 && !we_reg) begin
                rdata_reg <= data_in;
            end
        end
    end

    // Outputs decoded from state; addr/data_out keep their last value
    // through HOLD and IDLE so write data hold time is met.
    always_comb begin
        gnt     = 2'b00;
        rvalid  = 2'b00;
        ramcs_n = CS_IDLE;
        be_n    = BE_IDLE;
        xwe_n   = 1'b1;
        xrd_n   = 1'b1;
        data_oe = 1'b0;
        case (state_reg)
            SETUP: begin
                gnt     = port_mask(sel_reg);
                ramcs_n = 2'b00;
                be_n    = be_reg;
                data_oe = we_reg;
            end
            ACCESS: begin
                ramcs_n = 2'b00;
                be_n    = be_reg;
                data_oe = we_reg;
                xwe_n   = ~we_reg;
                xrd_n   = we_reg;
            end
            HOLD: begin
                ramcs_n = 2'b00;
                be_n    = be_reg;
                data_oe = we_reg;
                rvalid  = we_reg ? 2'b00 : port_mask(sel_reg);
            end
            default: ;
        endcase
    end

    assign addr     = addr_reg;
    assign data_out = wdata_reg;
    assign rdata    = rdata_reg;
    assign busy     = (state_reg != IDLE);

    // The pads must never drive while the SRAM outputs are enabled.
    no_bus_contention: assert property (@(posedge clk) disable iff (!reset_n)
        !(data_oe && !xrd_n));

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req, we;
    logic [17:0] p0_addr, p1_addr;
    logic [3:0]  p0_be_n, p1_be_n;
    logic [31:0] p0_wdata, p1_wdata;
    logic [1:0]  gnt, rvalid, ramcs_n;
    logic [31:0] rdata, data_out, data_in;
    logic        busy, xwe_n, xrd_n, data_oe;
    logic [17:0] addr;
    logic [3:0]  be_n;

    logic [1:0]  req_a, req_c, gnt_a, gnt_c, rvalid_a, rvalid_c, ramcs_n_a, ramcs_n_c;
    logic [31:0] rdata_a, rdata_c, data_out_a, data_out_c;
    logic        busy_a, busy_c, xwe_n_a, xwe_n_c, xrd_n_a, xrd_n_c, data_oe_a, data_oe_c;
    logic [17:0] addr_a, addr_c;
    logic [3:0]  be_n_a, be_n_c;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    sram_arbiter dut (
        .clk(clk), .reset_n(reset_n), .req(req), .we(we),
        .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_be_n(p0_be_n), .p1_be_n(p1_be_n),
        .p0_wdata(p0_wdata), .p1_wdata(p1_wdata), .gnt(gnt), .rvalid(rvalid),
        .rdata(rdata), .busy(busy), .addr(addr), .ramcs_n(ramcs_n), .be_n(be_n),
        .xwe_n(xwe_n), .xrd_n(xrd_n), .data_out(data_out), .data_oe(data_oe),
        .data_in(data_in)
    );

    sram_arbiter #(.WAIT_CYC(1)) u_w1 (
        .clk(clk), .reset_n(reset_n), .req(req_a), .we(we),
        .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_be_n(p0_be_n), .p1_be_n(p1_be_n),
        .p0_wdata(p0_wdata), .p1_wdata(p1_wdata), .gnt(gnt_a), .rvalid(rvalid_a),
        .rdata(rdata_a), .busy(busy_a), .addr(addr_a), .ramcs_n(ramcs_n_a), .be_n(be_n_a),
        .xwe_n(xwe_n_a), .xrd_n(xrd_n_a), .data_out(data_out_a), .data_oe(data_oe_a),
        .data_in(32'h0)
    );

    sram_arbiter #(.WAIT_CYC(15)) u_w15 (
        .clk(clk), .reset_n(reset_n), .req(req_c), .we(we),
        .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_be_n(p0_be_n), .p1_be_n(p1_be_n),
        .p0_wdata(p0_wdata), .p1_wdata(p1_wdata), .gnt(gnt_c), .rvalid(rvalid_c),
        .rdata(rdata_c), .busy(busy_c), .addr(addr_c), .ramcs_n(ramcs_n_c), .be_n(be_n_c),
        .xwe_n(xwe_n_c), .xrd_n(xrd_n_c), .data_out(data_out_c), .data_oe(data_oe_c),
        .data_in(32'h0)
    );

    // Behavioural asynchronous SRAM attached to the main instance.
    logic [31:0] sram_mem [0:262143];
    always @(posedge clk) begin
        if (ramcs_n == 2'b00 && !xwe_n) begin
            for (int b = 0; b < 4; b++)
                if (!be_n[b]) sram_mem[addr][8*b +: 8] <= data_out[8*b +: 8];
        end
    end
    assign data_in = (ramcs_n == 2'b00 && !xrd_n) ? sram_mem[addr] : 32'hA5A5_5A5A;

    // Reference model: arbitration rule and per-address memory contents.
    int last_m = 1;
    int streak_m = 0;

    function automatic int tie_winner();
`ifdef SRAM_ARB_FIXED_PRIO_EN
        return (streak_m >= 8) ? 1 : 0;
`else
        return 1 - last_m;
`endif
    endfunction

    task automatic model_grant(input int w, input bit both);
        last_m = w;
        streak_m = (w == 0 && both) ? streak_m + 1 : 0;
    endtask

    task automatic model_reset();
        last_m = 1;
        streak_m = 0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy; i++) tick();
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    typedef struct {
        bit          valid;
        bit          wr;
        int          idx;
        logic [3:0]  be;
        logic [31:0] data;
        int          set_cyc;
    } txn_t;

    initial begin
        txn_t        pend [2];
        logic [17:0] pool [16];
        logic [31:0] ref_mem [16];
        bit          written [16];
        int          rq_port [$];
        logic [31:0] rq_data [$];
        int          lo, lo_c, bz_a, bz_c, ng, expw, p, rv_early;
        bit          oe_seen, found, both, ok0, ok1;

        for (int i = 0; i < 16; i++) begin
            pool[i] = {4'(i), 14'(i * 37 + 5)};
            written[i] = 1'b0;
            ref_mem[i] = 32'h0;
        end
        pend[0] = '{default: 0};
        pend[1] = '{default: 0};

        reset_n = 1'b0;
        req = 2'b00; we = 2'b00; req_a = 2'b00; req_c = 2'b00;
        p0_addr = '0; p1_addr = '0; p0_be_n = 4'hF; p1_be_n = 4'hF;
        p0_wdata = '0; p1_wdata = '0;
        tick(); tick();

        // Reset state
        chk("rst_ramcs_n", 64'(ramcs_n), 64'h3);
        chk("rst_xwe_n", 64'(xwe_n), 64'd1);
        chk("rst_xrd_n", 64'(xrd_n), 64'd1);
        chk("rst_be_n", 64'(be_n), 64'hF);
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_data_out", 64'(data_out), 64'd0);
        chk("rst_data_oe", 64'(data_oe), 64'd0);
        chk("rst_gnt_rvalid", 64'({gnt, rvalid}), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset_n = 1'b1;
        tick();

        // Single write from port 0
        p0_addr = 18'h00123; p0_wdata = 32'hDEADBEEF; p0_be_n = 4'h0;
        we = 2'b01; req = 2'b01;
        tick();
        chk("wr_gnt", 64'(gnt), 64'h1);
        chk("wr_setup", 64'({data_oe, xwe_n, ramcs_n}), 64'({1'b1, 1'b1, 2'b00}));
        req = 2'b00;
        model_grant(0, 0);
        lo = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (!xwe_n) lo++;
            chk("wr_bus", 64'({data_oe, ramcs_n, addr, data_out}),
                64'({1'b1, 2'b00, 18'h00123, 32'hDEADBEEF}));
        end
        chk("wr_strobe_width", 64'(lo), 64'd2);
        tick();
        chk("wr_done", 64'({ramcs_n, data_oe, busy}), 64'({2'b11, 1'b0, 1'b0}));
        chk("wr_sram", 64'(sram_mem[18'h00123]), 64'hDEADBEEF);

        // Read back through port 1
        p1_addr = 18'h00123; we = 2'b00; req = 2'b10;
        tick();
        chk("rd_gnt", 64'(gnt), 64'h2);
        req = 2'b00;
        model_grant(1, 0);
        lo = 0; oe_seen = 0; rv_early = 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (!xrd_n) lo++;
            oe_seen |= data_oe;
            if (i < 3 && rvalid != 2'b00) rv_early++;
            if (i == 3) begin
                chk("rd_rvalid", 64'(rvalid), 64'h2);
                chk("rd_rdata", 64'(rdata), 64'hDEADBEEF);
            end
        end
        chk("rd_early_rvalid", 64'(rv_early), 64'd0);
        chk("rd_strobe_width", 64'(lo), 64'd2);
        chk("rd_no_oe", 64'(oe_seen), 64'd0);
        wait_idle();

        // Both ports requesting continuously
        p0_addr = 18'h00123; we = 2'b00; req = 2'b11;
        ng = 0;
        for (int i = 0; i < 200 && ng < 20; i++) begin
            tick();
            if (gnt != 2'b00) begin
                expw = tie_winner();
                chk("cont_gnt", 64'(gnt), (expw == 1) ? 64'h2 : 64'h1);
                model_grant(expw, 1);
                ng++;
            end
        end
        chk("cont_count", 64'(ng), 64'd20);
        req = 2'b00;
        wait_idle();

        // Asynchronous reset during the ACCESS phase of a write
        p0_addr = 18'h3FFFF; p0_wdata = 32'h12345678; we = 2'b01; req = 2'b01;
        tick();
        req = 2'b00;
        tick();
        chk("ar_in_access", 64'(xwe_n), 64'd0);
        #3 reset_n = 1'b0;
        #1;
        chk("ar_strobes", 64'({xwe_n, ramcs_n, data_oe, busy}), 64'({1'b1, 2'b11, 1'b0, 1'b0}));
        model_reset();
        tick();
        reset_n = 1'b1;
        ng = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (gnt != 2'b00 || rvalid != 2'b00) ng++;
        end
        chk("ar_no_pulses", 64'(ng), 64'd0);

        // Strobe width and occupancy at WAIT_CYC = 1 and 15
        p0_addr = 18'h00456; p0_wdata = 32'hCAFEF00D; p0_be_n = 4'h0; we = 2'b01;
        req_a = 2'b01; req_c = 2'b01;
        lo = 0; lo_c = 0; bz_a = 0; bz_c = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (gnt_a[0]) req_a = 2'b00;
            if (gnt_c[0]) req_c = 2'b00;
            if (!xwe_n_a) lo++;
            if (!xwe_n_c) lo_c++;
            if (busy_a) bz_a++;
            if (busy_c) bz_c++;
        end
        chk("w1_strobe", 64'(lo), 64'd1);
        chk("w1_occupancy", 64'(bz_a + 1), 64'd4);
        chk("w15_strobe", 64'(lo_c), 64'd15);
        chk("w15_occupancy", 64'(bz_c + 1), 64'd18);
        chk("aux_a_idle", 64'({ramcs_n_a, be_n_a, xrd_n_a, data_oe_a, rvalid_a, addr_a}),
            64'({2'b11, 4'hF, 1'b1, 1'b0, 2'b00, 18'h00456}));
        chk("aux_c_idle", 64'({ramcs_n_c, be_n_c, xrd_n_c, data_oe_c, rvalid_c, addr_c}),
            64'({2'b11, 4'hF, 1'b1, 1'b0, 2'b00, 18'h00456}));
        chk("aux_rdata", {rdata_a, rdata_c}, 64'd0);
        chk("aux_data_out", {data_out_a, data_out_c}, {32'hCAFEF00D, 32'hCAFEF00D});

        // Port 0 moves its address while port 1 owns the bus
        p1_addr = 18'h1F00F; p1_wdata = 32'h0BADF00D; p1_be_n = 4'h0; we = 2'b11; req = 2'b10;
        tick();
        chk("ac_gnt1", 64'(gnt), 64'h2);
        model_grant(1, 0);
        p0_addr = 18'h15550; p0_wdata = 32'h600DCAFE; req = 2'b01;
        tick();
        p0_addr = 18'h2AAA8;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (gnt[0]) found = 1;
        end
        chk("ac_gnt0_seen", 64'(found), 64'd1);
        model_grant(0, 0);
        req = 2'b00;
        chk("ac_addr", 64'(addr), 64'h2AAA8);
        wait_idle();
        chk("ac_sram", 64'(sram_mem[18'h2AAA8]), 64'h600DCAFE);

        // Randomized traffic against the reference model
        for (int t = 0; t < 700; t++) begin
            tick();
            if (gnt != 2'b00) begin
                p = gnt[1] ? 1 : 0;
                chk("rnd_gnt_onehot", 64'(gnt == 2'b01 || gnt == 2'b10), 64'd1);
                ok0 = pend[0].valid && pend[0].set_cyc < cyc;
                ok1 = pend[1].valid && pend[1].set_cyc < cyc;
                both = ok0 && ok1;
                expw = both ? tie_winner() : (ok0 ? 0 : 1);
                chk("rnd_winner", 64'(p), 64'(expw));
                model_grant(expw, both);
                chk("rnd_gnt_pending", 64'(pend[p].valid), 64'd1);
                if (pend[p].valid) begin
                    chk("rnd_addr_be", 64'({addr, be_n, data_oe}),
                        64'({pool[pend[p].idx], pend[p].be, pend[p].wr}));
                    if (pend[p].wr) begin
                        for (int b = 0; b < 4; b++)
                            if (!pend[p].be[b]) ref_mem[pend[p].idx][8*b +: 8] = pend[p].data[8*b +: 8];
                        written[pend[p].idx] = 1'b1;
                    end else begin
                        rq_port.push_back(p);
                        rq_data.push_back(ref_mem[pend[p].idx]);
                    end
                end
                pend[p].valid = 0;
                req[p] = 1'b0;
            end
            if (rvalid != 2'b00) begin
                chk("rnd_rvalid_expected", 64'(rq_port.size() != 0), 64'd1);
                if (rq_port.size() != 0) begin
                    chk("rnd_rvalid_port", 64'(rvalid), (rq_port[0] == 1) ? 64'h2 : 64'h1);
                    chk("rnd_rdata", 64'(rdata), 64'(rq_data[0]));
                    void'(rq_port.pop_front());
                    void'(rq_data.pop_front());
                end
            end
            if (t < 600) begin
                for (int q = 0; q < 2; q++) begin
                    if (!pend[q].valid && $urandom_range(0, 2) == 0) begin
                        pend[q].valid = 1;
                        pend[q].idx = $urandom_range(0, 15);
                        pend[q].wr = written[pend[q].idx] ? 1'($urandom_range(0, 1)) : 1'b1;
                        pend[q].be = written[pend[q].idx] ? 4'($urandom_range(0, 15)) : 4'h0;
                        pend[q].data = $urandom;
                        pend[q].set_cyc = cyc;
                        if (q == 0) begin
                            p0_addr = pool[pend[q].idx]; p0_be_n = pend[q].be; p0_wdata = pend[q].data;
                        end else begin
                            p1_addr = pool[pend[q].idx]; p1_be_n = pend[q].be; p1_wdata = pend[q].data;
                        end
                        we[q] = pend[q].wr;
                        req[q] = 1'b1;
                    end
                end
            end
        end
        chk("rnd_drained", 64'({pend[0].valid, pend[1].valid, rq_port.size() != 0, busy}), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
